// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: round-robin AHB-Lite bus arbiter, re-arbitrating only at hready-qualified transfer boundaries.
// Define AHB_ARB_LOCK_EN to honour hlock with a LOCKED state and hmastlock.
module ahb_rr_arbiter #(
    parameter int NUM_MST = 4,
    parameter int MW      = 2,
    parameter int DEF_MST = 0
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic [NUM_MST-1:0] hlock,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hburst,
    input  logic               hready,
    output logic [NUM_MST-1:0] hgrant,
    output logic [MW-1:0]      hmaster,
    output logic [MW-1:0]      hmaster_data,
    output logic               hmastlock
);
    localparam logic [MW-1:0] DEF = MW'(DEF_MST);

    typedef enum logic [1:0] {
        S_PARK,
        S_OWNED
`ifdef AHB_ARB_LOCK_EN
        , S_LOCKED
`endif
    } t_state;

    t_state               r_state, w_state_nxt, w_state_win;
    logic [MW-1:0]        r_last, r_hmaster, r_hmaster_data, w_last_nxt, w_owner_nxt, w_pick;
    logic [NUM_MST-1:0]   r_hgrant, w_grant_nxt;
    logic                 w_bnd, w_any, w_arb;

    // Scan last+1, last+2, ... wrapping; the owner itself (offset NUM_MST) comes last.
    function automatic logic [MW-1:0] f_pick(input logic [NUM_MST-1:0] req, input logic [MW-1:0] last);
        logic [MW-1:0] pick;
        pick = last;
        for (int k = NUM_MST; k >= 1; k--)
            if (req[(int'(last) + k) % NUM_MST]) pick = MW'((int'(last) + k) % NUM_MST);
        return pick;
    endfunction

    assign w_bnd  = htrans == 2'b00 || (htrans == 2'b10 && hburst == 3'b000);
    assign w_any  = |hbusreq;
    assign w_pick = f_pick(hbusreq, r_last);

`ifdef AHB_ARB_LOCK_EN
    assign w_arb       = r_state == S_PARK || (w_bnd && (r_state == S_OWNED || !hlock[r_hmaster]));
    assign w_state_win = hlock[w_pick] ? S_LOCKED : S_OWNED;
    assign hmastlock   = r_state == S_LOCKED;
`else
    logic w_unused;
    assign w_unused    = ^hlock;
    assign w_arb       = r_state == S_PARK || w_bnd;
    assign w_state_win = S_OWNED;
    assign hmastlock   = 1'b0;
`endif

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_state        <= S_PARK;
            r_last         <= DEF;
            r_hmaster      <= DEF;
            r_hmaster_data <= DEF;
            r_hgrant       <= NUM_MST'(1) << DEF_MST;
        end else if (hready) begin
            r_state        <= w_state_nxt;
            r_last         <= w_last_nxt;
            r_hmaster      <= w_owner_nxt;
            r_hmaster_data <= r_hmaster;
            r_hgrant       <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_hmaster;
        w_last_nxt  = r_last;
        if (w_arb) begin
            w_state_nxt = w_any ? w_state_win : S_PARK;
            w_owner_nxt = w_any ? w_pick : DEF;
            w_last_nxt  = w_any ? w_pick : r_last;
        end
    end

    always_comb begin
        w_grant_nxt = '0;
        w_grant_nxt[w_owner_nxt] = 1'b1;
    end

    assign hgrant       = r_hgrant;
    assign hmaster      = r_hmaster;
    assign hmaster_data = r_hmaster_data;
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter: directed vectors push expected post-edge outputs; a monitor pops and compares each cycle.
module tb_ahb_rr_arbiter;
    logic       hclk = 1'b0;
    logic       hresetn = 1'b0;
    logic [3:0] hbusreq = '0;
    logic [3:0] hlock = '0;
    logic [1:0] htrans = 2'b00;
    logic [2:0] hburst = 3'b000;
    logic       hready = 1'b1;
    logic [3:0] hgrant;
    logic [1:0] hmaster, hmaster_data;
    logic       hmastlock;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] m;
        logic [1:0] d;
        logic       l;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    ahb_rr_arbiter #(.NUM_MST(4), .MW(2), .DEF_MST(0)) dut (
        .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
        .htrans(htrans), .hburst(hburst), .hready(hready), .hgrant(hgrant),
        .hmaster(hmaster), .hmaster_data(hmaster_data), .hmastlock(hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge hclk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("hgrant", int'(hgrant), int'(e.g));
            chk("hmaster", int'(hmaster), int'(e.m));
            chk("hmaster_data", int'(hmaster_data), int'(e.d));
            chk("hmastlock", int'(hmastlock), int'(e.l));
        end
    end

    task automatic step(input logic rn, input logic [3:0] req, input logic [3:0] lk,
                        input logic [1:0] tr, input logic [2:0] hb, input logic rdy,
                        input logic [3:0] g, input logic [1:0] m, input logic [1:0] d, input logic l);
        @(negedge hclk);
        hresetn = rn; hbusreq = req; hlock = lk; htrans = tr; hburst = hb; hready = rdy;
        q.push_back('{g: g, m: m, d: d, l: l});
    endtask

    initial begin
        // reset and park
        step(0, 4'b0000, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 0, 0);
        step(0, 4'b0000, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 0, 0);
        step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 0, 0);
        step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 0, 0);
        // rotation with wrap
        step(1, 4'b1111, 4'b0000, NSEQ, SINGLE, 1, 4'b0010, 1, 0, 0);
        step(1, 4'b1111, 4'b0000, NSEQ, SINGLE, 1, 4'b0100, 2, 1, 0);
        step(1, 4'b1111, 4'b0000, NSEQ, SINGLE, 1, 4'b1000, 3, 2, 0);
        step(1, 4'b1111, 4'b0000, NSEQ, SINGLE, 1, 4'b0001, 0, 3, 0);
        step(1, 4'b1111, 4'b0000, NSEQ, SINGLE, 1, 4'b0010, 1, 0, 0);
        // INCR4 burst hold on master 2
        step(1, 4'b0100, 4'b0000, NSEQ, SINGLE, 1, 4'b0100, 2, 1, 0);
        step(1, 4'b1010, 4'b0000, NSEQ, INCR4,  1, 4'b0100, 2, 2, 0);
        step(1, 4'b1010, 4'b0000, SEQ,  INCR4,  1, 4'b0100, 2, 2, 0);
        step(1, 4'b1010, 4'b0000, SEQ,  INCR4,  1, 4'b0100, 2, 2, 0);
        step(1, 4'b1010, 4'b0000, SEQ,  INCR4,  1, 4'b0100, 2, 2, 0);
        step(1, 4'b1010, 4'b0000, IDLE, SINGLE, 1, 4'b1000, 3, 2, 0);
        // wait states / error response
        step(1, 4'b0010, 4'b0000, IDLE, SINGLE, 0, 4'b1000, 3, 2, 0);
        step(1, 4'b0010, 4'b0000, IDLE, SINGLE, 0, 4'b1000, 3, 2, 0);
        step(1, 4'b0010, 4'b0000, IDLE, SINGLE, 0, 4'b1000, 3, 2, 0);
        step(1, 4'b0010, 4'b0000, IDLE, SINGLE, 1, 4'b0010, 1, 3, 0);
        // park, then request from park uses pointer
        step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 1, 0);
        step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 0, 0);
        step(1, 4'b0100, 4'b0000, IDLE, SINGLE, 1, 4'b0100, 2, 0, 0);
        // BUSY and undefined-length NONSEQ are not boundaries
        step(1, 4'b0001, 4'b0000, BUSY, INCR,   1, 4'b0100, 2, 2, 0);
        step(1, 4'b0001, 4'b0000, NSEQ, INCR,   1, 4'b0100, 2, 2, 0);
        step(1, 4'b0001, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 2, 0);
        step(1, 4'b0001, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 0, 0);
        // reset mid-burst restores pointer too
        step(1, 4'b0010, 4'b0000, IDLE, SINGLE, 1, 4'b0010, 1, 0, 0);
        step(1, 4'b0010, 4'b0000, NSEQ, INCR4,  1, 4'b0010, 1, 1, 0);
        step(0, 4'b0010, 4'b0000, SEQ,  INCR4,  1, 4'b0001, 0, 0, 0);
        step(1, 4'b1111, 4'b0000, IDLE, SINGLE, 1, 4'b0010, 1, 0, 0);
        // locked sequence by master 3
`ifdef AHB_ARB_LOCK_EN
        step(1, 4'b1001, 4'b1000, IDLE, SINGLE, 1, 4'b1000, 3, 1, 1);
        step(1, 4'b1001, 4'b1000, NSEQ, SINGLE, 1, 4'b1000, 3, 3, 1);
        step(1, 4'b1001, 4'b1000, NSEQ, SINGLE, 1, 4'b1000, 3, 3, 1);
`else
        step(1, 4'b1001, 4'b1000, IDLE, SINGLE, 1, 4'b1000, 3, 1, 0);
        step(1, 4'b1001, 4'b1000, NSEQ, SINGLE, 1, 4'b0001, 0, 3, 0);
        step(1, 4'b1001, 4'b1000, NSEQ, SINGLE, 1, 4'b1000, 3, 0, 0);
`endif
        step(1, 4'b1001, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 3, 0);
        repeat (3) @(negedge hclk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
- Round-robin arbiter that shares one AHB-Lite bus segment between NUM_MST masters.
- Issues a one-hot grant and the address-phase and data-phase master indices. These drive the master-side address/control mux and write-data mux in front of the decoder and slaves, including the default slave.
- Re-arbitrates only on transfer boundaries qualified by system-wide hready. Active bursts and error responses are therefore never split.

Parameters:
- NUM_MST, 4, number of requesting masters (2..8)
- MW, 2, width of the master index; must satisfy 2**MW >= NUM_MST
- DEF_MST, 0, index of the master parked on the bus when nobody requests

Ports:
- hclk  in  1  bus clock
- hresetn  in  1  reset; synchronous, active-low, sampled on rising hclk
- hbusreq  in  NUM_MST  per-master bus request, level
- hlock  in  NUM_MST  per-master locked-sequence request (used only with the optional feature)
- htrans  in  2  htrans of the currently granted master (post-mux)
- hburst  in  3  hburst of the currently granted master (post-mux)
- hready  in  1  system-wide hready
- hgrant  out  NUM_MST  one-hot grant, registered
- hmaster  out  MW  address-phase owner index, registered
- hmaster_data  out  MW  data-phase owner index, registered
- hmastlock  out  1  current address phase is locked

Behaviour:
- Reset (hresetn=0 at a rising edge):
  - hgrant = one-hot(DEF_MST); hmaster = DEF_MST; hmaster_data = DEF_MST
  - hmastlock = 0; round-robin pointer last = DEF_MST; state = PARK
- State updates happen only on edges where hready=1. With hready=0, every register holds its value (wait states, including both error-response cycles).
- hmaster_data <= hmaster on every hready=1 edge, so it lags hmaster by exactly one accepted address phase.
- The boundary condition bnd is true when either:
  - htrans == IDLE (2'b00), or
  - htrans == NONSEQ (2'b10) and hburst == SINGLE (3'b000).
- Under SEQ (2'b11) or BUSY (2'b01), bnd is false and the grant is held.
- States:
  - PARK: no hbusreq bit set; the DEF_MST grant is held.
  - OWNED: the granted master is active.
  - LOCKED: exists only with the optional feature.
- Transitions, evaluated on hready=1:
  - PARK: any hbusreq bit set -> winner = first set bit scanning last+1, last+2, ... modulo NUM_MST. Load hgrant, hmaster and last with the winner; go to OWNED. No request -> stay in PARK.
  - OWNED with bnd:
    - Other requests pending -> round-robin pick excluding the current owner.
    - Only the owner requesting -> keep the grant.
    - No requests -> regrant DEF_MST, go to PARK.
  - OWNED without bnd: hold.
- Grant latency: a request sampled on hready=1 at edge N produces hgrant at N+1. The master drives its first NONSEQ in the cycle after it sees hgrant with hready=1.
- Simultaneous requests: strict rotation from last+1. Exactly one bit is ever set in hgrant.
- Indices >= NUM_MST are never produced. Pointer wrap: NUM_MST-1 -> 0.
- Dropping hbusreq mid-burst does not revoke the grant before bnd.
- Reset asserted mid-burst: immediate return to reset values at the next edge; no burst completion.

Optional Feature:
- Macro: AHB_ARB_LOCK_EN.
- Defined:
  - Granting a master whose hlock bit is 1 enters LOCKED, with hmastlock = 1 for that master's address phases.
  - In LOCKED, no re-arbitration occurs, regardless of bnd, until the owner's hlock = 0 is sampled at a bnd with hready=1. The arbiter then behaves as in OWNED.
  - hmastlock clears together with that re-arbitration edge.
- Undefined:
  - The hlock input is ignored.
  - hmastlock is tied to 0.
  - The LOCKED state does not exist.

Test Plan:
- Reset: hresetn=0 for 2 cycles -> hgrant=4'b0001, hmaster=0, hmaster_data=0, hmastlock=0; all hold with hbusreq=0.
- Rotation: hbusreq=4'b1111 with single NONSEQ transfers each cycle and hready=1 -> hmaster sequence 1,2,3,0,1; hmaster_data follows one cycle later.
- Burst hold: master 2 granted, INCR4 (NONSEQ,SEQ,SEQ,SEQ) with hbusreq=4'b1010 -> hgrant stays 4'b0100 for all 4 beats; 4'b1000 on the edge after the IDLE boundary.
- Wait/error: hready=0 for 3 cycles, then hready=1 (default slave two-cycle ERROR, hresp=1), with hbusreq=4'b0010 -> hgrant/hmaster unchanged during hready=0; update only after hready returns to 1.
- Park: all requests drop at a boundary -> next edge hgrant=4'b0001, state PARK; hbusreq=4'b0100 -> hgrant=4'b0100 one edge later.
- Lock (AHB_ARB_LOCK_EN): master 3 with hlock=1 across two single transfers, hbusreq=4'b1001 -> hgrant=4'b1000 and hmastlock=1 throughout; after hlock=0 at IDLE, hgrant=4'b0001 and hmastlock=0. Without the macro, the same stimulus rotates after the first transfer.
